// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage. Issues one word-aligned read at a time to the
//   instruction memory, buffers the returned word and presents it to the IF/ID
//   register until the pipeline accepts it. A redirect from ID
//   (branch_flag_i) discards the buffered or in-flight instruction. The
//   memory request is never withdrawn once issued, so a redirect that lands
//   mid-transaction is remembered and the stale data is dropped when it
//   arrives.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   stall[5:0]        stall vector from ctrl; bit 1 holds the IF/ID register
//   branch_flag_i     one-cycle redirect pulse from ID
//   branch_target_i   redirect address, qualified by branch_flag_i
//   mem_req_o         instruction memory read request
//   mem_addr_o        read address, held constant while mem_req_o is high
//   mem_ack_i         one-cycle completion pulse from memory
//   mem_rdata_i       instruction word, qualified by mem_ack_i
//   if_pc, if_inst    presented instruction and its address (zero = bubble)
//   if_stallreq       high whenever no instruction is being presented
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_stallreq
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      READY = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic [31:0] inst_buf;
   logic        squash;
   logic [31:0] squash_pc;

   // Only the IF/ID hold bit matters to this stage.
   logic        unused_stall;
   assign unused_stall = ^{stall[5:2], stall[0]};

   // Instruction addresses are always word aligned; low bits of a target are
   // dropped on capture.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   // Sequential next address, wrapping modulo 2^32.
   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         inst_buf  <= 32'h0;
         squash    <= 1'b0;
         squash_pc <= 32'h0;
      end else begin
         case (state)
            // Single dead cycle so memory sees req low and abandons any
            // transaction started before reset.
            IDLE: state <= BUSY;

            BUSY: begin
               if (branch_flag_i) begin
                  if (mem_ack_i) begin
                     // Redirect coincides with completion: drop the data and
                     // restart at the new target straight away.
                     fetch_pc <= word_align(branch_target_i);
                     squash   <= 1'b0;
                  end else begin
                     // Request stays up; remember where to go once the
                     // doomed transaction completes.
                     squash    <= 1'b1;
                     squash_pc <= word_align(branch_target_i);
                  end
               end else if (mem_ack_i) begin
                  if (squash) begin
                     fetch_pc <= squash_pc;
                     squash   <= 1'b0;
                  end else begin
                     inst_buf <= mem_rdata_i;
                     state    <= READY;
                  end
               end
            end

            READY: begin
               if (branch_flag_i) begin
                  fetch_pc <= word_align(branch_target_i);
                  state    <= BUSY;
               end else if (!stall[1]) begin
                  // IF/ID takes the instruction on this edge.
                  fetch_pc <= seq_pc(fetch_pc);
                  state    <= BUSY;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decode directly from registered state, so they change only on
   // clock edges.
   assign mem_req_o   = (state == BUSY);
   assign mem_addr_o  = fetch_pc;
   assign if_pc       = (state == READY) ? fetch_pc : 32'h0;
   assign if_inst     = (state == READY) ? inst_buf : 32'h0;
   assign if_stallreq = (state != READY);

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Randomized bench for inst_fetch. A memory model answers requests with a
//   random latency and a data word derived from the address. The stimulus
//   process drives stalls and redirects and pushes the address of every fetch
//   the program order calls for into a queue; a monitor pops that queue each
//   time a new instruction is presented and checks address and word.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_stallreq;

   logic        mem_auto;
   logic        a_ack;
   logic        man_ack;
   logic [31:0] a_data;
   logic [31:0] man_data;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model_pc;

   assign mem_ack_i   = mem_auto ? a_ack  : man_ack;
   assign mem_rdata_i = mem_auto ? a_data : man_data;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .mem_req_o       (mem_req_o),
      .mem_addr_o      (mem_addr_o),
      .mem_ack_i       (mem_ack_i),
      .mem_rdata_i     (mem_rdata_i),
      .if_pc           (if_pc),
      .if_inst         (if_inst),
      .if_stallreq     (if_stallreq)
   );

   // Instruction memory contents: address 0 holds addi x1,x0,5.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", nm, got, exp);
      end
   endtask

   // Memory: one transaction at a time, ack 1..3 cycles after the request is
   // first seen, aborted whenever req drops.
   initial begin
      int          cnt;
      logic        busy;
      logic [31:0] addr_l;
      a_ack = 1'b0; a_data = 32'h0; busy = 1'b0; cnt = 0; addr_l = 32'h0;
      forever begin
         @(posedge clk); #1;
         a_ack  = 1'b0;
         a_data = 32'h0;
         if (!mem_auto || rst || !mem_req_o) begin
            busy = 1'b0;
         end else if (busy) begin
            chk("req_addr_stable", mem_addr_o, addr_l);
            cnt--;
            if (cnt == 0) begin
               a_ack  = 1'b1;
               a_data = mem_word(addr_l);
               busy   = 1'b0;
            end
         end else begin
            busy   = 1'b1;
            addr_l = mem_addr_o;
            cnt    = $urandom_range(3, 1);
         end
      end
   end

   // Monitor: bubbles must be all-zero, each new presentation must match the
   // next expected fetch, and a held presentation must not change.
   initial begin
      logic        prev_pres;
      logic [31:0] cur_exp;
      int          gap;
      prev_pres = 1'b0; cur_exp = 32'h0; gap = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_pc", if_pc, 32'h0);
            chk("rst_inst", if_inst, 32'h0);
            chk("rst_stallreq", {31'd0, if_stallreq}, 32'd1);
            prev_pres = 1'b0;
            gap = 0;
         end else if (if_stallreq) begin
            chk("bubble_pc", if_pc, 32'h0);
            chk("bubble_inst", if_inst, 32'h0);
            prev_pres = 1'b0;
            gap++;
            if (gap > 200) begin
               total++; bad++;
               $display("FAIL fetch_timeout: got %0d cycles without an instruction, required <= 200", gap);
               gap = 0;
            end
         end else begin
            gap = 0;
            chk("present_req", {31'd0, mem_req_o}, 32'd0);
            if (!prev_pres) begin
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_inst: got pc %h inst %h, required no instruction", if_pc, if_inst);
                  cur_exp = if_pc;
               end else begin
                  cur_exp = exp_q.pop_front();
                  chk("inst_pc", if_pc, cur_exp);
                  chk("inst_word", if_inst, mem_word(cur_exp));
               end
            end else begin
               chk("hold_pc", if_pc, cur_exp);
               chk("hold_inst", if_inst, mem_word(cur_exp));
            end
            prev_pres = 1'b1;
         end
      end
   end

   task automatic random_phase(input int n);
      logic [31:0] tgt;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         stall         = 6'($urandom);
         stall[1]      = ($urandom_range(2, 0) == 0);
         branch_flag_i = 1'b0;
         if ((mem_req_o || !if_stallreq) && $urandom_range(9, 0) == 0) begin
            case ($urandom_range(3, 0))
               0:       tgt = 32'h0000_0100;
               1:       tgt = 32'h0000_0203;
               2:       tgt = 32'hFFFF_FFFC;
               default: tgt = $urandom;
            endcase
            branch_flag_i   = 1'b1;
            branch_target_i = tgt;
            model_pc        = tgt & 32'hFFFF_FFFC;
            // A presented instruction is already in (or out of) the queue;
            // anything not yet presented is cancelled by the redirect.
            if (if_stallreq) exp_q.delete();
            exp_q.push_back(model_pc);
         end else begin
            branch_target_i = $urandom;
            if (!if_stallreq && !stall[1]) begin
               model_pc = model_pc + 32'd4;
               exp_q.push_back(model_pc);
            end
         end
      end
   endtask

   task automatic reset_mid_busy();
      // Freeze memory so the fetch unit ends up waiting in BUSY.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            mem_auto      = 1'b0;
            man_ack       = 1'b0;
            man_data      = 32'hDEAD_BEEF;
            branch_flag_i = 1'b0;
            stall         = 6'h0;
         end
         if (!if_stallreq) begin
            model_pc = model_pc + 32'd4;
            exp_q.push_back(model_pc);
         end
      end
      chk("busy_before_rst", {31'd0, mem_req_o}, 32'd1);
      // Stale ack coincides with the reset edge and then lingers into IDLE.
      rst     = 1'b1;
      man_ack = 1'b1;
      exp_q.delete();
      model_pc = RESET_PC;
      exp_q.push_back(model_pc);
      @(posedge clk); #1;
      chk("rst_drop_req", {31'd0, mem_req_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle_req", {31'd0, mem_req_o}, 32'd0);
      chk("post_rst_idle_inst", if_inst, 32'h0);
      @(posedge clk); #1;
      man_ack = 1'b0;
      @(negedge clk);
      chk("post_rst_req", {31'd0, mem_req_o}, 32'd1);
      chk("post_rst_addr", mem_addr_o, RESET_PC);
      chk("post_rst_inst", if_inst, 32'h0);
      @(negedge clk);
      chk("post_rst_wait_req", {31'd0, mem_req_o}, 32'd1);
      chk("post_rst_wait_inst", if_inst, 32'h0);
      @(posedge clk); #1;
      mem_auto = 1'b1;
   endtask

   initial begin
      rst = 1'b1; stall = 6'h0; branch_flag_i = 1'b0; branch_target_i = 32'h0;
      mem_auto = 1'b1; man_ack = 1'b0; man_data = 32'h0;
      model_pc = RESET_PC;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      exp_q.push_back(model_pc);
      @(negedge clk);
      chk("idle_req", {31'd0, mem_req_o}, 32'd0);
      chk("idle_stallreq", {31'd0, if_stallreq}, 32'd1);
      @(negedge clk);
      chk("first_req", {31'd0, mem_req_o}, 32'd1);
      chk("first_addr", mem_addr_o, RESET_PC);
      random_phase(2500);
      reset_mid_busy();
      random_phase(1000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
